spi_ram_target: RTL and testbench

SPI_RAM_TARGET -- requirements
Module: spi_ram_target

---
 rtl/spi_ram_target.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_ram_target.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_target.sv
//------------------------------------------------------------------------------
// spi_ram_target
//   SPI (mode 0) target that fronts a small byte-wide RAM of 2^MEM_ADDR_BITS
//   bytes. Frames are: command byte, 16-bit address (MSB first), then a data
//   stream. 0x03 reads, 0x02 writes, and any other command is ignored until
//   chip select is released. The address auto-increments and wraps after each
//   data byte. All SPI inputs are oversampled by the system clock.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset (also clears the RAM)
//   spi_clk     SPI serial clock, idle low, at most clk/4
//   spi_select  active-low chip select
//   spi_mosi    serial data in, MSB first
//   spi_miso    serial data out, MSB first, driven only in READ
//   dbg_addr    backdoor read address
//   dbg_data    combinational RAM contents at dbg_addr
//   active      high in CMD, ADDR, READ and WRITE
//
// SPI timing: the initiator changes MOSI on SCK falling edges and samples
// MISO on SCK rising edges. This block samples MOSI on synchronised rising
// edges and updates MISO on synchronised falling edges.
//------------------------------------------------------------------------------
module spi_ram_target #(
   parameter int MEM_ADDR_BITS = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     spi_clk,
   input  logic                     spi_select,
   input  logic                     spi_mosi,
   output logic                     spi_miso,
   input  logic [MEM_ADDR_BITS-1:0] dbg_addr,
   output logic [7:0]               dbg_data,
   output logic                     active
);

   localparam int DEPTH = 1 << MEM_ADDR_BITS;
   // Receive shift width: wide enough for a command byte or the used address bits.
   localparam int SRW   = (MEM_ADDR_BITS > 8) ? MEM_ADDR_BITS : 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_READ,
      ST_WRITE,
      ST_IGNORE
   } state_t;

   // Synchronisers. Select resets to 0 so that a select already low when reset
   // releases never looks like a falling edge; a real high phase is required.
   logic sck_meta_q, sck_sync_q, sck_prev_q;
   logic sel_meta_q, sel_sync_q, sel_prev_q;
   logic mosi_meta_q, mosi_sync_q;

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [SRW-2:0]           sr_q, sr_d;
   logic [SRW-1:0]           sr_next;
   logic                     rd_q, rd_d;
   logic [MEM_ADDR_BITS-1:0] addr_q, addr_d, addr_inc;
   logic [7:0]               tx_q, tx_d;
   logic                     miso_q, miso_d;
   logic                     mem_we;
   logic [7:0]               mem_q [DEPTH];

   logic sck_rise, sck_fall, sel_fall, sel_rise;

   assign sck_rise = sck_sync_q & ~sck_prev_q;
   assign sck_fall = ~sck_sync_q & sck_prev_q;
   assign sel_fall = ~sel_sync_q & sel_prev_q;
   assign sel_rise = sel_sync_q & ~sel_prev_q;

   // Only the newest SRW bits are kept, which is what makes upper address bits alias.
   assign sr_next  = {sr_q, mosi_sync_q};
   assign addr_inc = addr_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_meta_q  <= 1'b0;
         sck_sync_q  <= 1'b0;
         sck_prev_q  <= 1'b0;
         sel_meta_q  <= 1'b0;
         sel_sync_q  <= 1'b0;
         sel_prev_q  <= 1'b0;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         sck_meta_q  <= spi_clk;
         sck_sync_q  <= sck_meta_q;
         sck_prev_q  <= sck_sync_q;
         sel_meta_q  <= spi_select;
         sel_sync_q  <= sel_meta_q;
         sel_prev_q  <= sel_sync_q;
         mosi_meta_q <= spi_mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         tx_q    <= '0;
         miso_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         tx_q    <= tx_d;
         miso_q  <= miso_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      tx_d    = tx_q;
      miso_d  = miso_q;
      mem_we  = 1'b0;
      if (sel_rise) begin
         // Deselect aborts from any state; a partially shifted byte is dropped.
         state_d = ST_IDLE;
         cnt_d   = '0;
         miso_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_fall) begin
                  state_d = ST_CMD;
                  cnt_d   = '0;
                  sr_d    = '0;
               end
            end
            ST_CMD: begin
               if (sck_rise) begin
                  sr_d  = sr_next[SRW-2:0];
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d = '0;
                     if (sr_next[7:0] == 8'h03) begin
                        rd_d    = 1'b1;
                        state_d = ST_ADDR;
                     end else if (sr_next[7:0] == 8'h02) begin
                        rd_d    = 1'b0;
                        state_d = ST_ADDR;
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end
            ST_ADDR: begin
               if (sck_rise) begin
                  sr_d  = sr_next[SRW-2:0];
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     cnt_d  = '0;
                     addr_d = sr_next[MEM_ADDR_BITS-1:0];
                     if (rd_q) begin
                        tx_d    = mem_q[sr_next[MEM_ADDR_BITS-1:0]];
                        state_d = ST_READ;
                     end else begin
                        state_d = ST_WRITE;
                     end
                  end
               end
            end
            ST_READ: begin
               if (sck_fall) begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
                  cnt_d  = cnt_q + 4'd1;
                  // The last bit of a byte goes out on this edge; preload the
                  // next byte so its MSB is ready on the following fall.
                  if (cnt_q == 4'd7) begin
                     cnt_d  = '0;
                     addr_d = addr_inc;
                     tx_d   = mem_q[addr_inc];
                  end
               end
            end
            ST_WRITE: begin
               if (sck_rise) begin
                  sr_d  = sr_next[SRW-2:0];
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d  = '0;
                     mem_we = 1'b1;
                     addr_d = addr_inc;
                  end
               end
            end
            ST_IGNORE: begin
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (mem_we) begin
         mem_q[addr_q] <= sr_next[7:0];
      end
   end

   assign dbg_data = mem_q[dbg_addr];
   assign spi_miso = (state_q == ST_READ) ? miso_q : 1'b0;
   assign active   = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                     (state_q == ST_READ) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_spi_ram_target.sv
//------------------------------------------------------------------------------
// tb_spi_ram_target
//   Directed bench for spi_ram_target (MEM_ADDR_BITS = 6). An SPI mode-0
//   initiator is modelled with tasks; the expected RAM image is kept by hand
//   in exp_mem and read-stream bytes go through exp_q.
//------------------------------------------------------------------------------
module tb_spi_ram_target;

   localparam int MAB   = 6;
   localparam int DEPTH = 64;
   localparam int HALF  = 50;  // SCK half period: 100 ns SCK vs 10 ns clk

   logic           clk = 1'b0;
   logic           rst_n;
   logic           spi_clk;
   logic           spi_select;
   logic           spi_mosi;
   logic           spi_miso;
   logic [MAB-1:0] dbg_addr;
   logic [7:0]     dbg_data;
   logic           active;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_mem [DEPTH];
   logic [7:0] exp_q [$];

   spi_ram_target #(.MEM_ADDR_BITS(MAB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_clk    (spi_clk),
      .spi_select (spi_select),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .active     (active)
   );

   // Clock / reset block: posedges at 5, 15, 25 ...; all stimulus moves on
   // multiples of 10 ns, i.e. on clk falling edges.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Shift the top n bits of tx out MSB first; rx collects MISO at each rise.
   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 8 - n; i--) begin
         spi_mosi = tx[i];
         #HALF;
         spi_clk  = 1'b1;
         rx[i]    = spi_miso;
         #HALF;
         spi_clk  = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      spi_bits(tx, 8, rx);
   endtask

   task automatic frame_start(input logic [7:0] cmd, input logic [15:0] a);
      logic [7:0] rx;
      spi_select = 1'b0;
      #100;
      spi_byte(cmd, rx);
      check_eq("miso during cmd", rx, 16'h0);
      spi_byte(a[15:8], rx);
      check_eq("miso during addr hi", rx, 16'h0);
      spi_byte(a[7:0], rx);
      check_eq("miso during addr lo", rx, 16'h0);
   endtask

   task automatic frame_end();
      #100;
      spi_select = 1'b1;
      #200;
   endtask

   task automatic check_mem_all(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         dbg_addr = i[MAB-1:0];
         #10;
         check_eq($sformatf("%s mem[%0d]", tag, i), dbg_data, exp_mem[i]);
      end
   endtask

   task automatic read_stream(input string tag, input int n);
      logic [7:0] rx;
      for (int i = 0; i < n; i++) begin
         spi_byte(8'h00, rx);
         check_eq($sformatf("%s byte %0d", tag, i), rx, exp_q.pop_front());
      end
   endtask

   initial begin
      logic [7:0] rx;
      rst_n      = 1'b0;
      spi_clk    = 1'b0;
      spi_select = 1'b1;
      spi_mosi   = 1'b0;
      dbg_addr   = '0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;

      // Reset state
      #100;
      check_eq("reset miso", spi_miso, 16'h0);
      check_eq("reset active", active, 16'h0);
      check_mem_all("reset");
      rst_n = 1'b1;
      #100;

      // SCK toggling with select high is ignored
      spi_byte(8'h02, rx);
      check_eq("idle sck active", active, 16'h0);
      check_eq("idle sck miso", rx, 16'h0);
      #200;

      // Single byte write at 0x05
      frame_start(8'h02, 16'h0005);
      check_eq("write active", active, 16'h1);
      spi_byte(8'hAB, rx);
      check_eq("write data miso", rx, 16'h0);
      frame_end();
      check_eq("after write active", active, 16'h0);
      exp_mem[5] = 8'hAB;
      check_mem_all("wr05");

      // Write across the top of memory, then stream read with wrap
      frame_start(8'h02, 16'h003F);
      spi_byte(8'h11, rx);
      spi_byte(8'h22, rx);
      frame_end();
      exp_mem[63] = 8'h11;
      exp_mem[0]  = 8'h22;
      frame_start(8'h03, 16'h003F);
      check_eq("read active", active, 16'h1);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      read_stream("rd3F", 2);
      frame_end();
      check_eq("miso idle after read", spi_miso, 16'h0);
      check_mem_all("wrap");

      // Partial byte is discarded; completed byte commits
      frame_start(8'h02, 16'h0010);
      spi_bits(8'hCD, 4, rx);
      frame_end();
      check_mem_all("partial");
      frame_start(8'h02, 16'h0010);
      spi_byte(8'hCD, rx);
      spi_bits(8'hEE, 4, rx);
      frame_end();
      exp_mem[16] = 8'hCD;
      check_mem_all("full+partial");

      // Unknown command is ignored
      spi_select = 1'b0;
      #100;
      spi_byte(8'h9F, rx);
      check_eq("9F cmd miso", rx, 16'h0);
      check_eq("9F active after cmd", active, 16'h0);
      for (int i = 0; i < 3; i++) begin
         spi_byte(8'hFF, rx);
         check_eq($sformatf("9F data %0d miso", i), rx, 16'h0);
         check_eq($sformatf("9F data %0d active", i), active, 16'h0);
      end
      frame_end();
      check_mem_all("ignore");

      // Address aliasing: 0x1205 hits the same cell as 0x0005
      frame_start(8'h02, 16'h1205);
      spi_byte(8'h5A, rx);
      frame_end();
      exp_mem[5] = 8'h5A;
      frame_start(8'h03, 16'h0005);
      exp_q.push_back(8'h5A);
      read_stream("alias", 1);
      frame_end();

      // Three-byte stream crossing the wrap point
      frame_start(8'h03, 16'h003E);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      read_stream("rd3E", 3);
      frame_end();

      // Reset pulse in the middle of a write data byte
      frame_start(8'h02, 16'h0008);
      spi_bits(8'hF0, 4, rx);
      rst_n = 1'b0;
      #20;
      check_eq("midreset active", active, 16'h0);
      check_eq("midreset miso", spi_miso, 16'h0);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
      check_mem_all("midreset");
      rst_n = 1'b1;
      #100;
      // Select is still low: the interrupted frame must not resume or restart
      spi_byte(8'h02, rx);
      check_eq("post-reset active", active, 16'h0);
      spi_byte(8'h00, rx);
      spi_byte(8'h08, rx);
      spi_byte(8'h99, rx);
      check_eq("post-reset active end", active, 16'h0);
      dbg_addr = 6'd8;
      #10;
      check_eq("post-reset mem[8]", dbg_data, 16'h0);
      frame_end();
      frame_start(8'h02, 16'h0008);
      spi_byte(8'h77, rx);
      frame_end();
      exp_mem[8] = 8'h77;
      frame_start(8'h03, 16'h0008);
      exp_q.push_back(8'h77);
      read_stream("recover", 1);
      frame_end();
      check_mem_all("recover");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
